// File: rtl/regfile_multiport.sv
// regfile_multiport: register file with one write port and NUM_RD registered read ports, GR0 hardwired to zero.
// Define REGFILE_BYPASS_EN to have a same-edge write forwarded to a read of the same address.
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     wr_err
);
  logic [DATA_W-1:0] mem [DEPTH-1:1];
  logic [NUM_RD*DATA_W-1:0] rd_next;
  logic in_range, wr_ok;
  // one extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W
  assign in_range = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_ok = wr_en && in_range && wr_addr != '0;
  always_comb begin
    rd_next = rd_data;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_req[k]) begin
        rd_next[k*DATA_W +: DATA_W] = '0;
        for (int i = 1; i < DEPTH; i++)
          if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) rd_next[k*DATA_W +: DATA_W] = mem[i];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && rd_addr[k*ADDR_W +: ADDR_W] == wr_addr) rd_next[k*DATA_W +: DATA_W] = wr_data;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
      wr_err   <= 1'b0;
    end else begin
      for (int i = 1; i < DEPTH; i++)
        if (wr_ok && wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
      rd_data  <= rd_next;
      rd_valid <= rd_req;
      wr_err   <= wr_en && !in_range;
    end
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed vectors for regfile_multiport (DEPTH=24, two read ports); honours REGFILE_BYPASS_EN.
module tb_regfile_multiport;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        wr_en = 0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_req = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_err;
  int total = 0;
  int bad = 0;

  regfile_multiport #(.DATA_W(32), .DEPTH(24), .NUM_RD(2), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic rd(input logic [1:0] req, input logic [4:0] a0, input logic [4:0] a1);
    rd_req = req; rd_addr = {a1, a0};
    tick();
    rd_req = 0;
  endtask

  initial begin
    #2;
    chk("rst_data", rd_data, 64'h0);
    chk("rst_valid", {62'h0, rd_valid}, 64'h0);
    chk("rst_err", {63'h0, wr_err}, 64'h0);
    tick();
    rst_n = 1;
    wr(5'd5, 32'hDEADBEEF);
    rd(2'b01, 5'd5, 5'd0);
    chk("r5_before_rst", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    chk("r5_valid", {62'h0, rd_valid}, 64'h1);
    #3 rst_n = 0;
    #1;
    chk("async_rst_data", rd_data, 64'h0);
    chk("async_rst_valid", {62'h0, rd_valid}, 64'h0);
    tick();
    rst_n = 1;
    rd(2'b11, 5'd5, 5'd5);
    chk("r5_after_rst", rd_data, 64'h0);
    chk("r5_after_rst_valid", {62'h0, rd_valid}, 64'h3);

    wr(5'd0, 32'hFFFFFFFF);
    rd(2'b11, 5'd0, 5'd0);
    chk("gr0_data", rd_data, 64'h0);
    chk("gr0_valid", {62'h0, rd_valid}, 64'h3);
    chk("gr0_err", {63'h0, wr_err}, 64'h0);

    wr(5'd3, 32'h11);
    wr(5'd7, 32'h22);
    rd(2'b11, 5'd3, 5'd7);
    chk("conc_data", rd_data, {32'h22, 32'h11});
    chk("conc_valid", {62'h0, rd_valid}, 64'h3);
    tick();
    chk("hold_data", rd_data, {32'h22, 32'h11});
    chk("hold_valid", {62'h0, rd_valid}, 64'h0);

    wr(5'd9, 32'hA);
    wr_en = 1; wr_addr = 5'd9; wr_data = 32'hB;
    rd(2'b01, 5'd9, 5'd0);
    wr_en = 0;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_same_edge", {32'h0, rd_data[31:0]}, 64'hB);
`else
    chk("rdw_same_edge", {32'h0, rd_data[31:0]}, 64'hA);
`endif
    rd(2'b10, 5'd0, 5'd9);
    chk("rdw_after", {32'h0, rd_data[63:32]}, 64'hB);

    wr(5'd30, 32'h55);
    chk("err_pulse", {63'h0, wr_err}, 64'h1);
    rd(2'b11, 5'd30, 5'd3);
    chk("err_cleared", {63'h0, wr_err}, 64'h0);
    chk("oob_read", rd_data, {32'h11, 32'h0});
    wr(5'd23, 32'h77);
    chk("last_addr_no_err", {63'h0, wr_err}, 64'h0);
    wr(5'd24, 32'h99);
    chk("first_oob_err", {63'h0, wr_err}, 64'h1);
    rd(2'b11, 5'd23, 5'd7);
    chk("last_addr_data", rd_data, {32'h22, 32'h77});
    rd(2'b11, 5'd24, 5'd9);
    chk("oob24_read", rd_data, {32'hB, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
